max7219_chain: RTL

Parametrised serial driver for a daisy chain of N_DEV MAX7219 LED drivers. One start strobe latches one 16-bit register write (address byte + data byte) per device and shifts all of them out in a single CS-low window, so every device latches its own frame on the CS rising edge. The whole block runs on the system clock and uses a clock-enable divider instead of a derived SPI clock. Devices can be masked so that they receive a no-op frame. It sits between the display controller logic and the MAX7219 pins (CS, CLK, Din).

---
 rtl/max7219_chain.sv | 132 +++++++++++++
 1 files changed

// File: rtl/max7219_chain.sv
// Serial driver for a daisy chain of MAX7219 devices: one strobe shifts one 16-bit
// register write per device out in a single CS-low window, timed by a clock-enable divider.
module max7219_chain #(
  parameter int unsigned N_DEV    = 4,
  parameter int unsigned HALF_DIV = 25
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                str,
  input  logic [16*N_DEV-1:0] frame,
  input  logic [N_DEV-1:0]    dev_en,
  output logic                busy,
  output logic                done,
  output logic                CS,
  output logic                CLK,
  output logic                Din
);

  localparam int unsigned B  = 16 * N_DEV;
  localparam int unsigned PW = $clog2(HALF_DIV + 1);
  localparam int unsigned BW = $clog2(B);
  localparam logic [PW-1:0] PhaseLast = PW'(HALF_DIV - 1);
  localparam logic [BW-1:0] BitLast   = BW'(B - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StHigh, StLow, StHold, StGap} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [B-1:0]  shift_q, shift_d;
  logic [B-1:0]  load;
  logic          cs_q, cs_d, clk_q, clk_d, din_q, din_d, done_q, done_d;
  logic          phase_end;

  // Masked devices get the MAX7219 no-op frame so the rest of the chain stays aligned.
  always_comb begin
    load = '0;
    for (int k = 0; k < int'(N_DEV); k++) begin
      load[16*k +: 16] = dev_en[k] ? frame[16*k +: 16] : 16'h0000;
    end
  end

  assign phase_end = (phase_q == PhaseLast);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    cs_d     = cs_q;
    clk_d    = clk_q;
    din_d    = din_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cs_d  = 1'b1;
        clk_d = 1'b0;
        din_d = 1'b0;
        if (str) begin
          shift_d  = load;
          bitcnt_d = BitLast;
          cs_d     = 1'b0;
          din_d    = load[B-1];
          state_d  = StSetup;
        end
      end
      StSetup, StLow: begin
        if (phase_end) begin
          clk_d   = 1'b1;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (phase_end) begin
          clk_d = 1'b0;
          if (bitcnt_q == '0) begin
            state_d = StHold;
          end else begin
            shift_d  = {shift_q[B-2:0], 1'b0};
            din_d    = shift_q[B-2];
            bitcnt_d = bitcnt_q - BW'(1);
            state_d  = StLow;
          end
        end
      end
      StHold: begin
        if (phase_end) begin
          cs_d    = 1'b1;
          din_d   = 1'b0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (phase_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Every phase end changes state, so clearing here clears on each state change.
    phase_d = (state_q == StIdle || phase_end) ? '0 : phase_q + PW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      cs_q     <= 1'b1;
      clk_q    <= 1'b0;
      din_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      cs_q     <= cs_d;
      clk_q    <= clk_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign CS   = cs_q;
  assign CLK  = clk_q;
  assign Din  = din_q;

endmodule
